// File: rtl/seq_mult_booth.sv
// Sequential add-shift multiplier for signed or unsigned WIDTH-bit operands.
// One add/subtract-and-shift per cycle, with a start/done handshake; Product is {A,B}.
module seq_mult_booth #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Signed_mode,
    input  logic [WIDTH-1:0]     S_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 X
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             x_q, sgn_q, busy_q, done_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH:0]   ext_a_s, ext_s_s, sum_s;
    logic [WIDTH-1:0] a_d, b_d;
    logic             x_d;

    // One iteration of the datapath: conditional add (or final subtract in signed mode), then shift.
    always_comb begin
        ext_a_s = {sgn_q & a_q[WIDTH-1], a_q};
        ext_s_s = {sgn_q & s_q[WIDTH-1], s_q};
        sum_s   = ext_a_s;
        if (b_q[0]) begin
            if ((count_q == LAST) && sgn_q) begin
                // Multiplier MSB carries negative weight in two's complement.
                sum_s = ext_a_s - ext_s_s;
            end else begin
                sum_s = ext_a_s + ext_s_s;
            end
        end else begin
            sum_s = ext_a_s;
        end
        a_d = {sum_s[WIDTH], sum_s[WIDTH-1:1]};
        b_d = {sum_s[0], b_q[WIDTH-1:1]};
        x_d = sgn_q ? sum_s[WIDTH] : 1'b0;
    end

    // Control FSM, operand/accumulator registers and registered handshake outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            x_q     <= 1'b0;
            sgn_q   <= 1'b0;
            count_q <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        s_q     <= S_in;
                        b_q     <= B_in;
                        a_q     <= {WIDTH{1'b0}};
                        x_q     <= 1'b0;
                        sgn_q   <= Signed_mode;
                        count_q <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    x_q     <= x_d;
                    count_q <= count_q + CW'(1);
                    busy_q  <= 1'b1;
                    if (count_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = {a_q, b_q};
    assign X       = x_q;

endmodule

// File: tb/tb_seq_mult_booth.sv
// Self-checking bench for seq_mult_booth: WIDTH=8 and WIDTH=4 instances against an
// arithmetic reference (plain integer multiply of sign- or zero-extended operands).
module tb_seq_mult_booth;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, mode8, busy8, done8, x8;
    logic [7:0]  s8, b8;
    logic [15:0] prod8;
    logic        start4, mode4, busy4, done4, x4;
    logic [3:0]  s4, b4;
    logic [7:0]  prod4;

    int n_cmp = 0;
    int n_bad = 0;

    seq_mult_booth #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset_n(rst_n), .Start(start8), .Signed_mode(mode8),
        .S_in(s8), .B_in(b8), .Busy(busy8), .Done(done8), .Product(prod8), .X(x8)
    );

    seq_mult_booth #(.WIDTH(4)) dut4 (
        .Clk(clk), .Reset_n(rst_n), .Start(start4), .Signed_mode(mode4),
        .S_in(s4), .B_in(b4), .Busy(busy4), .Done(done4), .Product(prod4), .X(x4)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input int w, input bit sgn,
                                             input logic [7:0] s, input logic [7:0] b);
        longint mask, sv, bv, p;
        mask = (longint'(1) << w) - 1;
        sv = longint'(s) & mask;
        bv = longint'(b) & mask;
        if (sgn && sv[w-1]) sv = sv - (longint'(1) << w);
        if (sgn && bv[w-1]) bv = bv - (longint'(1) << w);
        p = (sv * bv) & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    task automatic do_op(input bit w4, input bit sgn, input logic [7:0] s, input logic [7:0] b,
                         input bit scramble, input logic [15:0] exp, input string tag);
        int  w;
        bit  seen;
        w    = w4 ? 4 : 8;
        seen = 1'b0;
        @(negedge clk);
        if (w4) begin
            start4 = 1'b1; mode4 = sgn; s4 = s[3:0]; b4 = b[3:0];
        end else begin
            start8 = 1'b1; mode8 = sgn; s8 = s; b8 = b;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        for (int n = 1; n <= 3 * w; n++) begin
            @(negedge clk);
            if (w4 ? done4 : done8) begin
                check_val({tag, "_lat"}, 16'(n), 16'(w));
                check_val({tag, "_prod"}, w4 ? {8'h00, prod4} : prod8, exp);
                check_val({tag, "_busy"}, 16'(w4 ? busy4 : busy8), 16'd1);
                start4 = 1'b0;
                start8 = 1'b0;
                seen   = 1'b1;
                break;
            end
            if (scramble) begin
                if (w4) begin
                    start4 = 1'($urandom); mode4 = 1'($urandom);
                    s4 = 4'($urandom); b4 = 4'($urandom);
                end else begin
                    start8 = 1'($urandom); mode8 = 1'($urandom);
                    s8 = 8'($urandom); b8 = 8'($urandom);
                end
            end
        end
        if (!seen) check_val({tag, "_timeout"}, 16'd0, 16'd1);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 16'(w4 ? done4 : done8), 16'd0);
        check_val({tag, "_idle"}, 16'(w4 ? busy4 : busy8), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] q[$];
        logic [15:0] expv;
        logic [7:0]  rs, rb;
        bit          rm;
        int          dones, last_done, low_cnt;

        rst_n = 1'b0;
        start8 = 1'b0; mode8 = 1'b0; s8 = 8'h00; b8 = 8'h00;
        start4 = 1'b0; mode4 = 1'b0; s4 = 4'h0; b4 = 4'h0;
        repeat (2) @(negedge clk);
        check_val("rst_prod8", prod8, 16'h0000);
        check_val("rst_busy8", 16'(busy8), 16'd0);
        check_val("rst_done8", 16'(done8), 16'd0);
        check_val("rst_x8", 16'(x8), 16'd0);
        check_val("rst_prod4", {8'h00, prod4}, 16'h0000);
        rst_n = 1'b1;

        do_op(1'b0, 1'b1, 8'hF9, 8'h05, 1'b0, 16'hFFDD, "s_m7x5");
        do_op(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 16'h4000, "s_minxmin");
        do_op(1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 16'h4000, "u_80x80");
        do_op(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ffxff");
        do_op(1'b0, 1'b1, 8'h7F, 8'h80, 1'b0, 16'hC080, "s_7fx80");
        do_op(1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 16'h0000, "s_x0");
        do_op(1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 16'h0000, "u_0x");
        do_op(1'b0, 1'b1, 8'hF9, 8'h05, 1'b1, 16'hFFDD, "scramble");
        do_op(1'b1, 1'b1, 8'h08, 8'h07, 1'b0, 16'h00C8, "w4_s_m8x7");
        do_op(1'b1, 1'b0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, "w4_u_fxf");

        for (int i = 0; i < 40; i++) begin
            rs = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
            do_op(1'b0, rm, rs, rb, i[0], ref_prod(8, rm, rs, rb), "rand8");
        end
        for (int i = 0; i < 20; i++) begin
            rs = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15)); rm = 1'($urandom);
            do_op(1'b1, rm, rs, rb, i[0], ref_prod(4, rm, rs, rb), "rand4");
        end

        // Start held high: one accepted operation per idle cycle, fresh operands each time.
        dones = 0; last_done = -1; low_cnt = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done8) begin
                dones++;
                if (q.size() == 0) begin
                    check_val("held_queue", 16'd0, 16'd1);
                end else begin
                    expv = q.pop_front();
                    check_val("held_prod", prod8, expv);
                end
                if (last_done >= 0) begin
                    check_val("held_period", 16'(cyc - last_done), 16'd10);
                    check_val("held_busy_low", 16'(low_cnt), 16'd1);
                end
                last_done = cyc;
                low_cnt   = 0;
                if (dones == 3) begin
                    start8 = 1'b0;
                    break;
                end
            end
            if (!busy8) low_cnt++;
            s8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); start8 = 1'b1;
            if (!busy8) q.push_back(ref_prod(8, mode8, s8, b8));
        end
        start8 = 1'b0;
        check_val("held_dones", 16'(dones), 16'd3);

        // Asynchronous reset during RUN iteration 4 aborts without a Done pulse.
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; s8 = 8'h9C; b8 = 8'h6B;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_prod", prod8, 16'h0000);
        check_val("abort_busy", 16'(busy8), 16'd0);
        check_val("abort_done", 16'(done8), 16'd0);
        check_val("abort_x", 16'(x8), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check_val("abort_no_done", 16'(dones), 16'd0);
        do_op(1'b0, 1'b1, 8'h9C, 8'h6B, 1'b0, ref_prod(8, 1'b1, 8'h9C, 8'h6B), "after_abort");
        do_op(1'b0, 1'b1, 8'hF9, 8'h05, 1'b0, 16'hFFDD, "after_abort_dir");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_mult_booth.md
Name: seq_mult_booth

Overview:
- Parametrised sequential add-shift multiplier. Product of two WIDTH-bit operands is 2*WIDTH bits.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Generalises the fixed 8-bit adder/sign-extension datapath into a self-contained multiplier. It has its own control FSM, iteration counter and start/done handshake.
- Sits between the operand switch/register front end and the hex-display/result path.

Parameters:
- WIDTH, 8, operand width in bits (>=2). Product width is 2*WIDTH. Counter width is clog2(WIDTH).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Signed_mode  in  1  1 = signed operands, 0 = unsigned; latched at accepted Start.
- S_in  in  WIDTH  multiplicand; latched at accepted Start.
- B_in  in  WIDTH  multiplier; latched at accepted Start.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle pulse when Product becomes valid.
- Product  out  2*WIDTH  {A,B} result register; holds until next accepted Start.
- X  out  1  sign/extension bit of accumulator (debug/display).

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; A, B, S, X, count, sgn all 0. Busy=0, Done=0, Product=0. Reset mid-operation aborts immediately; no Done pulse follows.
- Registers:
  - A (WIDTH): accumulator.
  - B (WIDTH): multiplier, shifts right.
  - S (WIDTH): multiplicand.
  - X (1): extension bit.
  - sgn (1): latched Signed_mode.
  - count: iteration index.
- IDLE:
  - Start=1 loads S<=S_in, B<=B_in, A<=0, X<=0, sgn<=Signed_mode, count<=0, then goes to RUN.
  - Start=0: hold all registers.
- RUN, one iteration per cycle (add and shift combined):
  - Extended operands are WIDTH+1 bits: ext(v) = {sgn & v[MSB], v}.
  - If B[0]=1 and count<WIDTH-1: {X',A'} = ext(A) + ext(S), truncated to WIDTH+1 bits.
  - If B[0]=1 and count==WIDTH-1 and sgn=1: {X',A'} = ext(A) - ext(S). This is the sign-bit correction.
  - If B[0]=1 and count==WIDTH-1 and sgn=0: add, same as above.
  - If B[0]=0: {X',A'} = ext(A).
  - Shift: A <= {X',A'[WIDTH-1:1]}; B <= {A'[0],B[WIDTH-1:1]}; X <= sgn ? X' : 0.
  - count increments. After the iteration with count==WIDTH-1, go to DONE.
- DONE: Done=1 for exactly this cycle, then go to IDLE. Start is ignored in DONE.
- Latency: Start accepted at edge k. RUN occupies edges k+1..k+WIDTH. Done is high in the cycle after edge k+WIDTH, and Product is valid in that same cycle. Next Start can be accepted at edge k+WIDTH+2.
- Start held high continuously: a new operation is accepted every WIDTH+2 cycles, each taking fresh S_in/B_in/Signed_mode.
- Start, S_in, B_in, Signed_mode changing during RUN/DONE: no effect.
- Product = {A,B}.
  - Signed mode: exact two's-complement product for all operand pairs, including most-negative × most-negative, e.g. 8-bit −128×−128 = +16384. No overflow is possible in 2*WIDTH bits.
  - Unsigned mode: exact unsigned product.
- Busy = (state != IDLE).

Test Plan:
- WIDTH=8, signed, S_in=0xF9 (−7), B_in=0x05 → Done 9 cycles after Start edge, Product=0xFFDD (−35).
- WIDTH=8, signed, S_in=0x80, B_in=0x80 → Product=0x4000. Unsigned, same inputs → Product=0x4000. Unsigned 0xFF×0xFF → Product=0xFE01.
- WIDTH=8, signed 0x7F×0x80 → Product=0xC080 (−16256). Operands ×0 → Product=0x0000.
- WIDTH=8: change S_in/B_in/Start during RUN → result unchanged. Start held high → exactly one Done per 10 cycles, Busy low 1 cycle between operations.
- Assert Reset_n=0 at RUN iteration 4 → outputs 0 immediately (async), IDLE, no Done. Next operation computes correctly.
- WIDTH=4 instance, signed 0x8×0x7 (−8×7) → Product=0xC8 (−56), Done 5 cycles after Start. Unsigned 0xF×0xF → 0xE1.
